ovport_sched: RTL and testbench

Output-side scheduler for one switch egress port. It absorbs forwarded IPG words addressed to this port into per-(source port, message type) FIFOs. It then drains them onto a single transmit stream under three rules: message-atomic port locking per type, round-robin across source ports within a type, and strict type priority with a starvation guard. It has ready/valid backpressure on the transmit side and overflow accounting.

---
 rtl/ovport_sched.sv | 209 ++++++++++++++++++++
 tb/tb_ovport_sched.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ovport_sched.sv
// ovport_sched -- egress-port scheduler.
//
// Accepts forwarded IPG words addressed to this port into one FIFO per
// (message type, source port). It drains them onto a single registered
// transmit stream with three rules:
//   - per-type message locking, so a port's message is never split by
//     another port of the same type;
//   - round-robin across source ports within a type;
//   - strict type priority (type 0 highest), with a starvation guard that
//     forces a waiting lower type after STARVE_LIMIT lost grants.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_type/in_src/in_dst/in_data
//                       forwarded word; kept only when in_dst == OVPORT_ADR
//                       and in_src/in_type are in range
//   tx_valid/tx_ready   transmit handshake
//   tx_data/tx_type/tx_src/tx_last
//                       registered transmit word, its type, its source
//                       queue, and a delimiter flag
//   q_full              per-FIFO full flags, bit = type*PORT_NUM + port
//   drop_cnt            saturating count of words lost to a full FIFO
module ovport_sched #(
    parameter int OVPORT_ADR   = 2,
    parameter int PORT_NUM     = 16,
    parameter int TYPE_NUM     = 3,
    parameter int DATA_WIDTH   = 64,
    parameter int ADR_WIDTH    = 20,
    parameter int QUE_DEPTH    = 8,
    parameter int STARVE_LIMIT = 8,
    localparam int TYPE_W   = (TYPE_NUM > 1) ? $clog2(TYPE_NUM) : 1,
    localparam int PORT_W   = $clog2(PORT_NUM),
    localparam int QPTR_W   = (QUE_DEPTH > 1) ? $clog2(QUE_DEPTH) : 1,
    localparam int CNT_W    = $clog2(QUE_DEPTH) + 1,
    localparam int FIFO_NUM = TYPE_NUM * PORT_NUM,
    localparam int FIDX_W   = $clog2(FIFO_NUM)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [TYPE_W-1:0]        in_type,
    input  logic [ADR_WIDTH-1:0]     in_src,
    input  logic [ADR_WIDTH-1:0]     in_dst,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [DATA_WIDTH-1:0]    tx_data,
    output logic [TYPE_W-1:0]        tx_type,
    output logic [PORT_W-1:0]        tx_src,
    output logic                     tx_last,
    output logic [FIFO_NUM-1:0]      q_full,
    output logic [15:0]              drop_cnt
);

    function automatic logic [QPTR_W-1:0] ptr_inc(input logic [QPTR_W-1:0] p);
        ptr_inc = (p == QPTR_W'(QUE_DEPTH - 1)) ? '0 : p + QPTR_W'(1);
    endfunction

    // First non-empty port after 'start', wrapping through 'start' itself.
    // Scanning from the far end lets the nearest hit overwrite the result.
    function automatic logic [PORT_W:0] rr_search(input logic [PORT_NUM-1:0] row,
                                                  input logic [PORT_W-1:0]   start);
        logic [PORT_W-1:0] p;
        rr_search = '0;
        for (int k = PORT_NUM; k >= 1; k--) begin
            p = start + PORT_W'(k);
            if (row[p]) rr_search = {1'b1, p};
        end
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [DATA_WIDTH-1:0] mem    [FIFO_NUM][QUE_DEPTH];
    logic [QPTR_W-1:0]     wr_ptr [FIFO_NUM];
    logic [QPTR_W-1:0]     rd_ptr [FIFO_NUM];
    logic [CNT_W-1:0]      cnt    [FIFO_NUM];

    logic [TYPE_NUM-1:0]   lock_v;
    logic [PORT_W-1:0]     lock_p   [TYPE_NUM];
    logic [PORT_W-1:0]     rr_p     [TYPE_NUM];
    logic [7:0]            wait_cnt [TYPE_NUM];

    logic                  acc, full_in, push_ok, drop;
    logic [FIDX_W-1:0]     push_idx, pop_idx;
    logic [PORT_NUM-1:0]   ne_row [TYPE_NUM];
    logic [PORT_W:0]       srch   [TYPE_NUM];
    logic [PORT_W-1:0]     cand   [TYPE_NUM];
    logic [TYPE_NUM-1:0]   elig;
    logic                  starve_hit, grant, load, head_last;
    logic [TYPE_W-1:0]     sel;
    logic [PORT_W-1:0]     sel_port;
    logic [DATA_WIDTH-1:0] head;

    // Stage 0: ingress qualification and FIFO occupancy view
    always_comb begin
        acc = in_valid && (in_dst == ADR_WIDTH'(OVPORT_ADR))
              && ({1'b0, in_src} < (ADR_WIDTH + 1)'(PORT_NUM))
              && ({1'b0, in_type} < (TYPE_W + 1)'(TYPE_NUM));
        push_idx = FIDX_W'(int'(in_type) * PORT_NUM + int'(in_src[PORT_W-1:0]));
        // Full is judged on the registered count, so a same-cycle pop
        // does not rescue the incoming word.
        full_in  = (cnt[push_idx] == CNT_W'(QUE_DEPTH));
        push_ok  = acc && !full_in;
        drop     = acc && full_in;
        for (int f = 0; f < FIFO_NUM; f++) q_full[f] = (cnt[f] == CNT_W'(QUE_DEPTH));
        for (int t = 0; t < TYPE_NUM; t++)
            for (int p = 0; p < PORT_NUM; p++)
                ne_row[t][p] = (cnt[t * PORT_NUM + p] != '0);
    end

    // Stage 0: candidate per type, then type arbitration
    always_comb begin
        starve_hit = 1'b0;
        sel        = '0;
        for (int t = 0; t < TYPE_NUM; t++) begin
            srch[t] = rr_search(ne_row[t], rr_p[t]);
            if (lock_v[t]) begin
                cand[t] = lock_p[t];
                elig[t] = ne_row[t][lock_p[t]];
            end else begin
                cand[t] = srch[t][PORT_W-1:0];
                elig[t] = srch[t][PORT_W];
            end
        end
        for (int t = TYPE_NUM - 1; t >= 1; t--)
            if (STARVE_LIMIT != 0 && elig[t] && wait_cnt[t] == 8'(STARVE_LIMIT)) begin
                starve_hit = 1'b1;
                sel        = TYPE_W'(t);
            end
        if (!starve_hit)
            for (int t = TYPE_NUM - 1; t >= 0; t--)
                if (elig[t]) sel = TYPE_W'(t);
        grant     = |elig;
        sel_port  = cand[sel];
        pop_idx   = FIDX_W'(int'(sel) * PORT_NUM + int'(sel_port));
        head      = mem[pop_idx][rd_ptr[pop_idx]];
        head_last = (head[7:4] == 4'd0);
        load      = grant && (!tx_valid || tx_ready);
    end

    // Stage 0 -> FIFO storage (data is not reset; occupancy is)
    always_ff @(posedge clk) begin
        if (push_ok) mem[push_idx][wr_ptr[push_idx]] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int f = 0; f < FIFO_NUM; f++) begin
                cnt[f]    <= '0;
                wr_ptr[f] <= '0;
                rd_ptr[f] <= '0;
            end
        end else begin
            for (int f = 0; f < FIFO_NUM; f++) begin
                if (push_ok && push_idx == FIDX_W'(f)) wr_ptr[f] <= ptr_inc(wr_ptr[f]);
                if (load && pop_idx == FIDX_W'(f))     rd_ptr[f] <= ptr_inc(rd_ptr[f]);
                case ({push_ok && push_idx == FIDX_W'(f), load && pop_idx == FIDX_W'(f)})
                    2'b10:   cnt[f] <= cnt[f] + CNT_W'(1);
                    2'b01:   cnt[f] <= cnt[f] - CNT_W'(1);
                    default: ;
                endcase
            end
        end
    end

    // Stage 1: output register and scheduler state
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
            tx_type  <= '0;
            tx_src   <= '0;
            tx_last  <= 1'b0;
            drop_cnt <= '0;
            lock_v   <= '0;
            for (int t = 0; t < TYPE_NUM; t++) begin
                lock_p[t]   <= '0;
                rr_p[t]     <= '1;
                wait_cnt[t] <= '0;
            end
        end else begin
            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            if (load) begin
                tx_valid <= 1'b1;
                tx_data  <= head;
                tx_type  <= sel;
                tx_src   <= sel_port;
                tx_last  <= head_last;
                for (int t = 0; t < TYPE_NUM; t++) begin
                    if (TYPE_W'(t) == sel) begin
                        rr_p[t]     <= sel_port;
                        lock_v[t]   <= !head_last;
                        lock_p[t]   <= sel_port;
                        wait_cnt[t] <= '0;
                    end else if (t > 0 && elig[t]) begin
                        wait_cnt[t] <= sat_inc8(wait_cnt[t]);
                    end else begin
                        wait_cnt[t] <= '0;
                    end
                end
            end else if (tx_ready) begin
                tx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ovport_sched.sv
// Bench for ovport_sched: directed scenarios with fixed expected orders,
// plus randomized traffic compared each cycle against a queue-based model.
module tb_ovport_sched;

    localparam int P  = 16;
    localparam int T  = 3;
    localparam int D  = 8;
    localparam int SL = 4;

    logic        clk, rst, in_valid, tx_ready;
    logic [1:0]  in_type;
    logic [19:0] in_src, in_dst;
    logic [63:0] in_data;
    logic        tx_valid, tx_last;
    logic [63:0] tx_data;
    logic [1:0]  tx_type;
    logic [3:0]  tx_src;
    logic [47:0] q_full;
    logic [15:0] drop_cnt;

    ovport_sched #(.OVPORT_ADR(2), .PORT_NUM(P), .TYPE_NUM(T), .DATA_WIDTH(64),
                   .ADR_WIDTH(20), .QUE_DEPTH(D), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_type(in_type),
        .in_src(in_src), .in_dst(in_dst), .in_data(in_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .tx_type(tx_type), .tx_src(tx_src), .tx_last(tx_last),
        .q_full(q_full), .drop_cnt(drop_cnt));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [63:0] mq [P*T][$];
    bit          m_lock_v [T];
    int          m_lock_p [T], m_rr [T], m_wait [T];
    bit          m_valid, m_last;
    logic [63:0] m_data;
    int          m_type, m_src, m_drop;

    int          checks, failures, cyc;
    logic [63:0] log_data [$];
    int          log_cyc [$];
    logic [63:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int f = 0; f < P*T; f++) mq[f].delete();
        for (int t = 0; t < T; t++) begin
            m_lock_v[t] = 0; m_lock_p[t] = 0; m_rr[t] = P - 1; m_wait[t] = 0;
        end
        m_valid = 0; m_last = 0; m_data = '0; m_type = 0; m_src = 0; m_drop = 0;
    endtask

    task automatic model_step();
        int cand [T];
        int g, idx;
        bit acc, full_pre;
        logic [63:0] w;
        if (rst) begin
            model_reset();
        end else begin
            for (int t = 0; t < T; t++) begin
                cand[t] = -1;
                if (m_lock_v[t]) begin
                    if (mq[t*P + m_lock_p[t]].size() > 0) cand[t] = m_lock_p[t];
                end else begin
                    for (int k = 1; k <= P; k++)
                        if (cand[t] < 0 && mq[t*P + (m_rr[t] + k) % P].size() > 0)
                            cand[t] = (m_rr[t] + k) % P;
                end
            end
            g = -1;
            for (int t = 1; t < T; t++)
                if (g < 0 && SL != 0 && cand[t] >= 0 && m_wait[t] == SL) g = t;
            for (int t = 0; t < T; t++)
                if (g < 0 && cand[t] >= 0) g = t;
            acc = in_valid && in_dst == 20'd2 && in_src < 20'(P) && in_type < 2'(T);
            idx = int'(in_type) * P + int'(in_src[3:0]);
            full_pre = acc && mq[idx].size() == D;
            if (g >= 0 && (!m_valid || tx_ready)) begin
                w = mq[g*P + cand[g]].pop_front();
                m_valid = 1; m_data = w; m_type = g; m_src = cand[g];
                m_last = (w[7:4] == 4'd0);
                m_rr[g] = cand[g]; m_lock_p[g] = cand[g]; m_lock_v[g] = !m_last;
                for (int t = 0; t < T; t++) begin
                    if (t == g) m_wait[t] = 0;
                    else if (t > 0 && cand[t] >= 0) m_wait[t] = (m_wait[t] < 255) ? m_wait[t] + 1 : 255;
                    else m_wait[t] = 0;
                end
            end else if (tx_ready) begin
                m_valid = 0;
            end
            if (acc) begin
                if (full_pre) begin
                    if (m_drop < 65535) m_drop++;
                end else begin
                    mq[idx].push_back(in_data);
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic [47:0] ef;
        chk("tx_valid", tx_valid, m_valid);
        if (m_valid) begin
            chk("tx_data", tx_data, m_data);
            chk("tx_type", tx_type, 64'(m_type));
            chk("tx_src", tx_src, 64'(m_src));
            chk("tx_last", tx_last, m_last);
        end
        chk("drop_cnt", drop_cnt, 64'(m_drop));
        for (int f = 0; f < P*T; f++) ef[f] = (mq[f].size() == D);
        chk("q_full", q_full, ef);
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        if (tx_valid && tx_ready) begin
            log_data.push_back(tx_data);
            log_cyc.push_back(cyc);
        end
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        in_valid = 0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic push(input int t, input int s, input int d, input logic [63:0] data);
        in_valid = 1; in_type = 2'(t); in_src = 20'(s); in_dst = 20'(d); in_data = data;
        cycle();
        in_valid = 0;
    endtask

    task automatic do_reset();
        rst = 1; in_valid = 0;
        cycle(); cycle();
        rst = 0;
        log_data.delete(); log_cyc.delete(); exp_q.delete();
    endtask

    task automatic check_seq(input string tag);
        chk({tag, "_count"}, 64'(log_data.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_data.size(); i++)
            chk(tag, log_data[i], exp_q[i]);
    endtask

    int s0;
    logic [63:0] held;

    initial begin
        checks = 0; failures = 0; cyc = 0;
        rst = 1; in_valid = 0; in_type = '0; in_src = '0; in_dst = '0; in_data = '0;
        tx_ready = 1;
        model_reset();
        do_reset();
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_q_full", q_full, 0);

        // Single message, latency 2
        s0 = cyc;
        push(0, 3, 2, 64'hA1_1A); push(0, 3, 2, 64'hA2_1A); push(0, 3, 2, 64'hA3_0D);
        idle(6);
        exp_q.push_back(64'hA1_1A); exp_q.push_back(64'hA2_1A); exp_q.push_back(64'hA3_0D);
        check_seq("single");
        if (log_cyc.size() > 0) chk("single_latency", 64'(log_cyc[0] - s0), 2);

        // Port lock within a type
        do_reset();
        push(0, 1, 2, 64'hB1_1A); push(0, 2, 2, 64'hC1_1A);
        push(0, 1, 2, 64'hB2_0D); push(0, 2, 2, 64'hC2_0D);
        idle(8);
        exp_q.push_back(64'hB1_1A); exp_q.push_back(64'hB2_0D);
        exp_q.push_back(64'hC1_1A); exp_q.push_back(64'hC2_0D);
        check_seq("lock");

        // Priority interleave mid-message
        do_reset();
        push(2, 0, 2, 64'hD1_1A); push(2, 0, 2, 64'hD2_1A); push(0, 5, 2, 64'hE1_0D);
        push(2, 0, 2, 64'hD3_1A); push(2, 0, 2, 64'hD4_0D);
        idle(8);
        exp_q.push_back(64'hD1_1A); exp_q.push_back(64'hD2_1A); exp_q.push_back(64'hE1_0D);
        exp_q.push_back(64'hD3_1A); exp_q.push_back(64'hD4_0D);
        check_seq("prio");
        if (log_cyc.size() > 2) chk("prio_next_cycle", 64'(log_cyc[2] - log_cyc[1]), 1);

        // Starvation guard: type 2 wins on its 5th grant opportunity
        do_reset();
        tx_ready = 0;
        for (int i = 0; i < 6; i++) push(0, i, 2, 64'hF0_0D + (64'(i) << 8));
        push(2, 9, 2, 64'h77_0D);
        tx_ready = 1;
        idle(12);
        for (int i = 0; i < 5; i++) exp_q.push_back(64'hF0_0D + (64'(i) << 8));
        exp_q.push_back(64'h77_0D);
        exp_q.push_back(64'hF5_0D);
        check_seq("starve");

        // Backpressure and overflow
        do_reset();
        tx_ready = 0;
        for (int i = 0; i < 10; i++) push(1, 7, 2, 64'h50_1A + (64'(i) << 8));
        idle(1);
        chk("ovf_q_full_bit", q_full[23], 1);
        chk("ovf_drop", drop_cnt, 1);
        chk("ovf_hold_data", tx_data, 64'h50_1A);
        held = tx_data;
        idle(2);
        chk("ovf_stable", tx_data, held);
        tx_ready = 1;
        idle(14);
        for (int i = 0; i < 9; i++) exp_q.push_back(64'h50_1A + (64'(i) << 8));
        check_seq("ovf");
        chk("ovf_drop_after", drop_cnt, 1);

        // Filtering
        do_reset();
        push(0, 3, 7, 64'h61_0D); push(0, P, 2, 64'h62_0D); push(3, 1, 2, 64'h63_0D);
        idle(5);
        check_seq("filter");
        chk("filter_drop", drop_cnt, 0);

        // Reset mid-message; round robin restarts at port 0
        do_reset();
        push(0, 3, 2, 64'h31_0D); push(0, 4, 2, 64'h41_1A);
        idle(3);
        push(0, 4, 2, 64'h42_1A);
        rst = 1;
        cycle();
        rst = 0;
        chk("midrst_valid", tx_valid, 0);
        chk("midrst_data", tx_data, 0);
        chk("midrst_src", tx_src, 0);
        chk("midrst_last", tx_last, 0);
        chk("midrst_q_full", q_full, 0);
        log_data.delete(); log_cyc.delete();
        tx_ready = 0;
        push(1, 0, 2, 64'h90_0D); push(0, 5, 2, 64'h95_0D); push(0, 2, 2, 64'h92_0D);
        idle(1);
        tx_ready = 1;
        idle(6);
        exp_q.push_back(64'h90_0D); exp_q.push_back(64'h92_0D); exp_q.push_back(64'h95_0D);
        check_seq("rr_restart");

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            logic [63:0] d;
            in_valid = ($urandom % 4) != 0;
            in_type  = 2'($urandom % 4);
            in_src   = (($urandom % 8) == 0) ? 20'(P + $urandom % 2) : 20'($urandom % 4);
            in_dst   = (($urandom % 10) == 0) ? 20'd7 : 20'd2;
            d        = {$urandom, $urandom};
            d[7:4]   = (($urandom % 3) == 0) ? 4'd0 : 4'(1 + $urandom % 15);
            in_data  = d;
            tx_ready = ((i / 500) % 2 == 0) ? ($urandom % 2 == 0) : ($urandom % 10 != 0);
            rst      = ($urandom % 700) == 0;
            cycle();
        end
        rst = 0;
        idle(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
